// File: rtl/rv64_trap_ctrl_if.sv
// Commit-stage request channel into the machine-mode trap sequencer.
// XLEN defaults to 64 when the `XLEN macro is not supplied by the build.
`ifndef XLEN
`define XLEN 64
`endif

// Handshake: a request transfers on a rising edge where req_valid_i && req_ready_o.
// The payload must be stable while valid is high; the master may drop valid freely.
interface rv64_trap_ctrl_if #(
  parameter int XLEN = `XLEN
);
  logic            req_valid_i;
  logic            req_ready_o;
  logic            req_mret_i;
  logic [5:0]      req_cause_i;
  logic [XLEN-1:0] req_pc_i;
  logic [XLEN-1:0] req_tval_i;

  modport master (
    output req_valid_i, req_mret_i, req_cause_i, req_pc_i, req_tval_i,
    input  req_ready_o
  );

  modport slave (
    input  req_valid_i, req_mret_i, req_cause_i, req_pc_i, req_tval_i,
    output req_ready_o
  );
endinterface

// File: rtl/rv64_trap_ctrl.sv
// Machine-mode trap sequencer: exception/interrupt/mret -> CSR write strobes -> PC redirect.
// Optional TRAP_VECTORED_EN: vectored interrupt targets when mtvec mode is 2'b01.
`ifndef XLEN
`define XLEN 64
`endif

module rv64_trap_ctrl #(
  parameter int XLEN = `XLEN
) (
  input  logic             clk,
  input  logic             rst,
  rv64_trap_ctrl_if.slave  req,
  input  logic             irq_i,
  input  logic [XLEN-1:0]  irq_pc_i,
  input  logic [XLEN-1:0]  csr_mstatus_i,
  input  logic [XLEN-1:0]  csr_mepc_i,
  input  logic [XLEN-1:0]  csr_mtvec_i,
  output logic [XLEN-1:0]  csr_mstatus_o,
  output logic [XLEN-1:0]  csr_mepc_o,
  output logic [XLEN-1:0]  csr_mcause_o,
  output logic [XLEN-1:0]  csr_mtval_o,
  output logic             csr_mstatus_valid_o,
  output logic             csr_mepc_valid_o,
  output logic             csr_mcause_valid_o,
  output logic             csr_mtval_valid_o,
  output logic             redirect_valid_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             busy_o,
  output logic [1:0]       state_dbg_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SAVE     = 2'd1,
    RESTORE  = 2'd2,
    REDIRECT = 2'd3
  } state_e;

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  state_e          state_q, state_d;
  logic            irq_q, irq_d;
  logic            mret_q, mret_d;
  logic [5:0]      code_q, code_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tval_q, tval_d;

  logic            irq_pend;
  logic            take_exc;
  logic            take_irq;
  logic            take_mret;
  logic [XLEN-1:0] mstatus_save;
  logic [XLEN-1:0] mstatus_restore;
  logic [XLEN-1:0] trap_target;

  // Exceptions beat interrupts, interrupts beat mret; a pending interrupt
  // holds ready low so a simultaneous mret is not consumed.
  assign irq_pend  = irq_i & csr_mstatus_i[3];
  assign take_exc  = req.req_valid_i & ~req.req_mret_i;
  assign take_irq  = ~take_exc & irq_pend;
  assign take_mret = req.req_valid_i & req.req_mret_i & ~irq_pend;

  assign req.req_ready_o = rst & (state_q == IDLE) & ~(irq_pend & req.req_mret_i);
  assign busy_o          = (state_q != IDLE);
  assign state_dbg_o     = state_q;

  always_comb begin
    mstatus_save        = csr_mstatus_i;
    mstatus_save[7]     = csr_mstatus_i[3];
    mstatus_save[3]     = 1'b0;
    mstatus_save[12:11] = 2'b11;
  end

  always_comb begin
    mstatus_restore        = csr_mstatus_i;
    mstatus_restore[3]     = csr_mstatus_i[7];
    mstatus_restore[7]     = 1'b1;
    mstatus_restore[12:11] = 2'b11;
  end

  always_comb begin
    trap_target = csr_mtvec_i & ALIGN_MASK;
`ifdef TRAP_VECTORED_EN
    if (irq_q && (csr_mtvec_i[1:0] == 2'b01)) begin
      trap_target = (csr_mtvec_i & ALIGN_MASK) + {{(XLEN-8){1'b0}}, code_q, 2'b00};
    end
`endif
  end

  always_comb begin
    state_d             = state_q;
    irq_d               = irq_q;
    mret_d              = mret_q;
    code_d              = code_q;
    pc_d                = pc_q;
    tval_d              = tval_q;
    csr_mstatus_valid_o = 1'b0;
    csr_mepc_valid_o    = 1'b0;
    csr_mcause_valid_o  = 1'b0;
    csr_mtval_valid_o   = 1'b0;
    csr_mstatus_o       = '0;
    csr_mepc_o          = '0;
    csr_mcause_o        = '0;
    csr_mtval_o         = '0;
    redirect_valid_o    = 1'b0;
    redirect_pc_o       = '0;

    case (state_q)
      IDLE: begin
        if (take_exc) begin
          state_d = SAVE;
          irq_d   = 1'b0;
          mret_d  = 1'b0;
          code_d  = req.req_cause_i;
          pc_d    = req.req_pc_i;
          tval_d  = req.req_tval_i;
        end else if (take_irq) begin
          state_d = SAVE;
          irq_d   = 1'b1;
          mret_d  = 1'b0;
          code_d  = 6'd7;
          pc_d    = irq_pc_i;
          tval_d  = '0;
        end else if (take_mret) begin
          state_d = RESTORE;
          irq_d   = 1'b0;
          mret_d  = 1'b1;
          code_d  = '0;
          pc_d    = req.req_pc_i;
          tval_d  = '0;
        end
      end
      SAVE: begin
        csr_mstatus_valid_o = 1'b1;
        csr_mepc_valid_o    = 1'b1;
        csr_mcause_valid_o  = 1'b1;
        csr_mtval_valid_o   = 1'b1;
        csr_mstatus_o       = mstatus_save;
        csr_mepc_o          = pc_q & ALIGN_MASK;
        csr_mcause_o        = {irq_q, {(XLEN-7){1'b0}}, code_q};
        csr_mtval_o         = tval_q;
        state_d             = REDIRECT;
      end
      RESTORE: begin
        csr_mstatus_valid_o = 1'b1;
        csr_mstatus_o       = mstatus_restore;
        state_d             = REDIRECT;
      end
      REDIRECT: begin
        // CSR inputs already reflect the writes captured at the end of SAVE/RESTORE.
        redirect_valid_o = 1'b1;
        redirect_pc_o    = mret_q ? (csr_mepc_i & ALIGN_MASK) : trap_target;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
      mret_q  <= 1'b0;
      code_q  <= '0;
      pc_q    <= '0;
      tval_q  <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
      mret_q  <= mret_d;
      code_q  <= code_d;
      pc_q    <= pc_d;
      tval_q  <= tval_d;
    end
  end

endmodule

// File: tb/tb_rv64_trap_ctrl.sv
// Self-checking bench for rv64_trap_ctrl: scenario tasks plus an output scoreboard.
module tb_rv64_trap_ctrl;
  localparam int XLEN = 64;

  typedef struct packed {
    logic            is_redir;
    logic [3:0]      mask;      // {mstatus, mepc, mcause, mtval}
    logic [XLEN-1:0] mstatus;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mtval;
    logic [XLEN-1:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   redir_cnt = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv64_trap_ctrl_if #(.XLEN(XLEN)) req_if ();

  logic            irq_i;
  logic [XLEN-1:0] irq_pc_i, csr_mstatus_i, csr_mepc_i, csr_mtvec_i;
  logic [XLEN-1:0] csr_mstatus_o, csr_mepc_o, csr_mcause_o, csr_mtval_o;
  logic            csr_mstatus_valid_o, csr_mepc_valid_o, csr_mcause_valid_o, csr_mtval_valid_o;
  logic            redirect_valid_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            busy_o;
  logic [1:0]      state_dbg_o;

  rv64_trap_ctrl #(.XLEN(XLEN)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req                 (req_if),
    .irq_i               (irq_i),
    .irq_pc_i            (irq_pc_i),
    .csr_mstatus_i       (csr_mstatus_i),
    .csr_mepc_i          (csr_mepc_i),
    .csr_mtvec_i         (csr_mtvec_i),
    .csr_mstatus_o       (csr_mstatus_o),
    .csr_mepc_o          (csr_mepc_o),
    .csr_mcause_o        (csr_mcause_o),
    .csr_mtval_o         (csr_mtval_o),
    .csr_mstatus_valid_o (csr_mstatus_valid_o),
    .csr_mepc_valid_o    (csr_mepc_valid_o),
    .csr_mcause_valid_o  (csr_mcause_valid_o),
    .csr_mtval_valid_o   (csr_mtval_valid_o),
    .redirect_valid_o    (redirect_valid_o),
    .redirect_pc_o       (redirect_pc_o),
    .busy_o              (busy_o),
    .state_dbg_o         (state_dbg_o)
  );

  // ---------------- reference model ----------------
  function automatic logic [XLEN-1:0] m_save(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r = m;
    r[7] = m[3];
    r[3] = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] m_restore(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r = m;
    r[3] = m[7];
    r[7] = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic exp_t exp_wr(input logic [3:0] mask, input logic [XLEN-1:0] ms,
                                  input logic [XLEN-1:0] mepc, input logic [XLEN-1:0] mcause,
                                  input logic [XLEN-1:0] mtval);
    exp_t e;
    e = '{1'b0, mask, ms, mepc, mcause, mtval, {XLEN{1'b0}}};
    return e;
  endfunction

  function automatic exp_t exp_redir(input logic [XLEN-1:0] pc);
    exp_t e;
    e = '{1'b1, 4'b0000, {XLEN{1'b0}}, {XLEN{1'b0}}, {XLEN{1'b0}}, {XLEN{1'b0}}, pc};
    return e;
  endfunction

  function automatic logic [XLEN-1:0] irq_target(input logic [XLEN-1:0] mtvec);
    logic [XLEN-1:0] base;
    base = {mtvec[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    if (mtvec[1:0] == 2'b01) base = base + 64'd28;
`endif
    return base;
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic [3:0] mon_mask;
  exp_t       mon_e;
  always @(negedge clk) begin
    mon_mask = {csr_mstatus_valid_o, csr_mepc_valid_o, csr_mcause_valid_o, csr_mtval_valid_o};
    if (redirect_valid_o === 1'b1) redir_cnt++;
    if (mon_mask !== 4'b0000 || redirect_valid_o !== 1'b0) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected: got mask=%b redir=%b pc=%h, required no output",
                 mon_mask, redirect_valid_o, redirect_pc_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_mask !== mon_e.mask || redirect_valid_o !== mon_e.is_redir ||
            (mon_e.mask[3] && csr_mstatus_o !== mon_e.mstatus) ||
            (mon_e.mask[2] && csr_mepc_o !== mon_e.mepc) ||
            (mon_e.mask[1] && csr_mcause_o !== mon_e.mcause) ||
            (mon_e.mask[0] && csr_mtval_o !== mon_e.mtval) ||
            (mon_e.is_redir && redirect_pc_o !== mon_e.pc)) begin
          tests_failed++;
          $display("FAIL sb_event: got mask=%b redir=%b ms=%h mepc=%h mcause=%h mtval=%h pc=%h; required mask=%b redir=%b ms=%h mepc=%h mcause=%h mtval=%h pc=%h",
                   mon_mask, redirect_valid_o, csr_mstatus_o, csr_mepc_o, csr_mcause_o, csr_mtval_o,
                   redirect_pc_o, mon_e.mask, mon_e.is_redir, mon_e.mstatus, mon_e.mepc, mon_e.mcause,
                   mon_e.mtval, mon_e.pc);
        end
      end
    end
    tests_run++;
    if ((!csr_mstatus_valid_o && csr_mstatus_o !== '0) || (!csr_mepc_valid_o && csr_mepc_o !== '0) ||
        (!csr_mcause_valid_o && csr_mcause_o !== '0) || (!csr_mtval_valid_o && csr_mtval_o !== '0) ||
        (!redirect_valid_o && redirect_pc_o !== '0)) begin
      tests_failed++;
      $display("FAIL data_zero: got ms=%h mepc=%h mcause=%h mtval=%h pc=%h with strobes low, required 0",
               csr_mstatus_o, csr_mepc_o, csr_mcause_o, csr_mtval_o, redirect_pc_o);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic mret, input logic [5:0] cause,
                           input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tval);
    req_if.req_valid_i = 1'b1;
    req_if.req_mret_i  = mret;
    req_if.req_cause_i = cause;
    req_if.req_pc_i    = pc;
    req_if.req_tval_i  = tval;
    @(posedge clk);
    #1;
    req_if.req_valid_i = 1'b0;
  endtask

  task automatic drive_irq(input logic [XLEN-1:0] pc);
    irq_i    = 1'b1;
    irq_pc_i = pc;
    @(posedge clk);
    #1;
    irq_i = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if (req_if.req_ready_o !== 1'b0 || busy_o !== 1'b0 || state_dbg_o !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got ready=%b busy=%b state=%0d, required 0 0 0",
               req_if.req_ready_o, busy_o, state_dbg_o);
    end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (req_if.req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: got ready=%b busy=%b, required 1 0", req_if.req_ready_o, busy_o);
    end
  endtask

  task automatic test_exception();
    csr_mstatus_i = 64'h8;
    csr_mtvec_i   = 64'h8000_1000;
    csr_mepc_i    = 64'h0;
    exp_q.push_back(exp_wr(4'b1111, 64'h1880, 64'h8000_0104, 64'd2, 64'hDEAD));
    exp_q.push_back(exp_redir(64'h8000_1000));
    drive_req(1'b0, 6'd2, 64'h8000_0104, 64'hDEAD);
    @(negedge clk);
    tests_run++;
    if (state_dbg_o !== 2'd1 || busy_o !== 1'b1 || req_if.req_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL exc_t1: got state=%0d busy=%b ready=%b, required 1 1 0",
               state_dbg_o, busy_o, req_if.req_ready_o);
    end
    @(negedge clk);
    tests_run++;
    if (redirect_valid_o !== 1'b1 || state_dbg_o !== 2'd3) begin
      tests_failed++;
      $display("FAIL exc_t2: got redirect=%b state=%0d, required 1 3", redirect_valid_o, state_dbg_o);
    end
    @(negedge clk);
    tests_run++;
    if (req_if.req_ready_o !== 1'b1 || busy_o !== 1'b0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL exc_t3: got ready=%b busy=%b pending=%0d, required 1 0 0",
               req_if.req_ready_o, busy_o, exp_q.size());
    end
  endtask

  task automatic test_mret();
    csr_mstatus_i = 64'h1880;
    csr_mepc_i    = 64'h8000_0108;
    exp_q.push_back(exp_wr(4'b1000, 64'h1888, 64'h0, 64'h0, 64'h0));
    exp_q.push_back(exp_redir(64'h8000_0108));
    drive_req(1'b1, 6'd0, 64'h8000_0050, 64'h0);
    @(negedge clk);
    tests_run++;
    if (state_dbg_o !== 2'd2) begin
      tests_failed++;
      $display("FAIL mret_state: got state=%0d, required 2", state_dbg_o);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL mret_done: got pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_interrupt();
    csr_mstatus_i = 64'h8;
    csr_mtvec_i   = 64'h8000_1001;
    exp_q.push_back(exp_wr(4'b1111, 64'h1880, 64'h8000_0200, 64'h8000_0000_0000_0007, 64'h0));
`ifdef TRAP_VECTORED_EN
    exp_q.push_back(exp_redir(64'h8000_101C));
`else
    exp_q.push_back(exp_redir(64'h8000_1000));
`endif
    drive_irq(64'h8000_0200);
    repeat (3) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_done: got pending=%0d busy=%b, required 0 0", exp_q.size(), busy_o);
    end
  endtask

  task automatic test_priority();
    // exception + irq + MIE: exception wins, still goes to base in vectored mode
    csr_mstatus_i = 64'h8;
    csr_mtvec_i   = 64'h8000_1001;
    irq_i         = 1'b1;
    irq_pc_i      = 64'h8000_0300;
    exp_q.push_back(exp_wr(4'b1111, 64'h1880, 64'h8000_0400, 64'd5, 64'h1234));
    exp_q.push_back(exp_redir(64'h8000_1000));
    drive_req(1'b0, 6'd5, 64'h8000_0402, 64'h1234);
    irq_i = 1'b0;
    repeat (3) @(negedge clk);
    // irq with MIE=0 + mret: mret wins
    csr_mstatus_i = 64'h1880;
    csr_mepc_i    = 64'h8000_0500;
    irq_i         = 1'b1;
    exp_q.push_back(exp_wr(4'b1000, 64'h1888, 64'h0, 64'h0, 64'h0));
    exp_q.push_back(exp_redir(64'h8000_0500));
    drive_req(1'b1, 6'd0, 64'h0, 64'h0);
    irq_i = 1'b0;
    repeat (3) @(negedge clk);
    // irq with MIE=1 + mret: interrupt taken, mret refused
    csr_mstatus_i         = 64'h8;
    csr_mtvec_i           = 64'h8000_2000;
    irq_i                 = 1'b1;
    irq_pc_i              = 64'h8000_0600;
    req_if.req_valid_i    = 1'b1;
    req_if.req_mret_i     = 1'b1;
    #1;
    tests_run++;
    if (req_if.req_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL prio_mret_ready: got ready=%b, required 0", req_if.req_ready_o);
    end
    exp_q.push_back(exp_wr(4'b1111, 64'h1880, 64'h8000_0600, 64'h8000_0000_0000_0007, 64'h0));
    exp_q.push_back(exp_redir(64'h8000_2000));
    @(posedge clk);
    #1;
    irq_i              = 1'b0;
    req_if.req_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL prio_done: got pending=%0d busy=%b, required 0 0", exp_q.size(), busy_o);
    end
  endtask

  task automatic test_reset_mid();
    int r0;
    r0 = redir_cnt;
    csr_mstatus_i = 64'h8;
    csr_mtvec_i   = 64'h8000_1000;
    drive_req(1'b0, 6'd3, 64'h8000_0700, 64'h77);
    tests_run++;
    if (csr_mepc_valid_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL rmid_save: got mepc_valid=%b, required 1", csr_mepc_valid_o);
    end
    #1;
    rst = 1'b0;
    #1;
    tests_run++;
    if (csr_mstatus_valid_o !== 1'b0 || csr_mepc_valid_o !== 1'b0 || csr_mcause_valid_o !== 1'b0 ||
        csr_mtval_valid_o !== 1'b0 || csr_mepc_o !== '0 || busy_o !== 1'b0 || req_if.req_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rmid_abort: got strobes=%b%b%b%b mepc=%h busy=%b ready=%b, required all 0",
               csr_mstatus_valid_o, csr_mepc_valid_o, csr_mcause_valid_o, csr_mtval_valid_o,
               csr_mepc_o, busy_o, req_if.req_ready_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (req_if.req_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL rmid_release: got ready=%b, required 1", req_if.req_ready_o);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (redir_cnt != r0 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rmid_noredir: got redirects=%0d busy=%b, required 0 0", redir_cnt - r0, busy_o);
    end
  endtask

  task automatic test_back_to_back();
    int r0;
    r0 = redir_cnt;
    csr_mstatus_i = 64'h8;
    csr_mtvec_i   = 64'h8000_3000;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(exp_wr(4'b1111, 64'h1880, 64'h8000_0120, 64'd11, 64'hBEEF));
      exp_q.push_back(exp_redir(64'h8000_3000));
    end
    req_if.req_valid_i = 1'b1;
    req_if.req_mret_i  = 1'b0;
    req_if.req_cause_i = 6'd11;
    req_if.req_pc_i    = 64'h8000_0123;
    req_if.req_tval_i  = 64'hBEEF;
    @(posedge clk);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      tests_run++;
      if (req_if.req_ready_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_busy_t%0d: got ready=%b, required 0", c, req_if.req_ready_o);
      end
    end
    @(negedge clk);
    tests_run++;
    if (req_if.req_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_t3_ready: got ready=%b, required 1", req_if.req_ready_o);
    end
    @(posedge clk);
    #1;
    req_if.req_valid_i = 1'b0;
    repeat (5) @(negedge clk);
    tests_run++;
    if (redir_cnt - r0 != 2 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL b2b_count: got redirects=%0d pending=%0d, required 2 0", redir_cnt - r0, exp_q.size());
    end
  endtask

  task automatic test_random();
    logic [XLEN-1:0] ms, tv, pc, tval;
    logic [5:0]      cause;
    for (int i = 0; i < 6; i++) begin
      ms    = {$urandom, $urandom};
      tv    = {$urandom, $urandom};
      pc    = {$urandom, $urandom};
      tval  = {$urandom, $urandom};
      cause = 6'($urandom_range(0, 63));
      csr_mstatus_i = ms;
      csr_mtvec_i   = tv;
      csr_mepc_i    = pc;
      case ($urandom_range(0, 2))
        0: begin
          exp_q.push_back(exp_wr(4'b1111, m_save(ms), {pc[XLEN-1:2], 2'b00}, {58'd0, cause}, tval));
          exp_q.push_back(exp_redir({tv[XLEN-1:2], 2'b00}));
          drive_req(1'b0, cause, pc, tval);
        end
        1: begin
          exp_q.push_back(exp_wr(4'b1000, m_restore(ms), 64'h0, 64'h0, 64'h0));
          exp_q.push_back(exp_redir({pc[XLEN-1:2], 2'b00}));
          drive_req(1'b1, cause, tval, tval);
        end
        default: begin
          ms[3] = 1'b1;
          tv[1:0] = 2'b01;
          csr_mstatus_i = ms;
          csr_mtvec_i   = tv;
          exp_q.push_back(exp_wr(4'b1111, m_save(ms), {pc[XLEN-1:2], 2'b00}, 64'h8000_0000_0000_0007, 64'h0));
          exp_q.push_back(exp_redir(irq_target(tv)));
          drive_irq(pc);
        end
      endcase
      repeat (3) @(negedge clk);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL rand_done: got pending=%0d, required 0", exp_q.size());
    end
  endtask

  initial begin
    rst                = 1'b0;
    irq_i              = 1'b0;
    irq_pc_i           = '0;
    csr_mstatus_i      = '0;
    csr_mepc_i         = '0;
    csr_mtvec_i        = '0;
    req_if.req_valid_i = 1'b0;
    req_if.req_mret_i  = 1'b0;
    req_if.req_cause_i = '0;
    req_if.req_pc_i    = '0;
    req_if.req_tval_i  = '0;
    test_reset();
    test_exception();
    test_mret();
    test_interrupt();
    test_priority();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rv64_trap_ctrl.md
# rv64_trap_ctrl

Machine-mode trap sequencer that sits directly upstream of `rv64_csr_regfile`. It accepts exception, interrupt and `mret` requests from the commit stage. It drives the regfile's dedicated mstatus/mepc/mcause/mtval write ports with one-cycle valid strobes, then issues a single-cycle PC redirect to mtvec or mepc. The front end and commit stage are held off while a trap sequence is in flight.

## Interface
Parameters:
- `XLEN`, 64, datapath width (taken from `` `XLEN ``).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (low = in reset).
- `req_valid_i`  in  1  commit-stage request valid.
- `req_ready_o`  out  1  block can accept a request.
- `req_mret_i`  in  1  request is `mret` (0 = synchronous exception).
- `req_cause_i`  in  6  exception code (ignored for `mret`).
- `req_pc_i`  in  XLEN  PC of the faulting or `mret` instruction.
- `req_tval_i`  in  XLEN  trap value (ignored for `mret`).
- `irq_i`  in  1  level machine timer interrupt, already synchronous.
- `irq_pc_i`  in  XLEN  resume PC if the interrupt is taken.
- `csr_mstatus_i`, `csr_mepc_i`, `csr_mtvec_i`  in  XLEN  current regfile values.
- `csr_mstatus_o`, `csr_mepc_o`, `csr_mcause_o`, `csr_mtval_o`  out  XLEN  write data to the regfile.
- `csr_mstatus_valid_o`, `csr_mepc_valid_o`, `csr_mcause_valid_o`, `csr_mtval_valid_o`  out  1  write strobes.
- `redirect_valid_o`  out  1  one-cycle PC redirect pulse.
- `redirect_pc_o`  out  XLEN  redirect target.
- `busy_o`  out  1  sequence in flight; the front end stalls and flushes.

## Operation
- FSM states: IDLE, SAVE, RESTORE, REDIRECT.
- IDLE, selection priority (highest first):
  - `req_valid_i` with `req_mret_i=0`: exception.
  - `irq_i && csr_mstatus_i[3]` (MIE): interrupt.
  - `req_valid_i` with `req_mret_i=1`: `mret`.
- `req_ready_o = (state==IDLE)`; it is 0 while `rst` is low.
- An interrupt is taken only when no exception is presented. It is accepted even when `req_valid_i=0`. If an `mret` is presented at the same time, the `mret` is not accepted and `req_ready_o` stays low that cycle.
- Accept cycle: latch the kind, cause, pc and tval into internal registers.
- Exception/interrupt path: IDLE→SAVE→REDIRECT→IDLE.
- `mret` path: IDLE→RESTORE→REDIRECT→IDLE.
- SAVE asserts all four strobes for exactly one cycle:
  - mepc = latched pc with bits[1:0] cleared.
  - mcause = `{irq, {XLEN-7{0}}, code}`; code = `req_cause_i` for exceptions, 7 for interrupts.
  - mtval = `req_tval_i` for exceptions, 0 for interrupts.
  - mstatus = `csr_mstatus_i` with MPIE[7]←MIE[3], MIE←0, MPP[12:11]←2'b11; other bits unchanged.
- RESTORE asserts only `csr_mstatus_valid_o`: MIE←MPIE, MPIE←1, MPP←2'b11.
- REDIRECT: `redirect_valid_o=1` for one cycle.
  - Trap: target = mtvec base `{csr_mtvec_i[XLEN-1:2],2'b00}` (see Configuration).
  - `mret`: target = `{csr_mepc_i[XLEN-1:2],2'b00}`.
- `busy_o` = (state != IDLE).
- Every strobe and redirect output is 0 in any state where it is not explicitly asserted. Data outputs read 0 when their strobe is low.

## Timing
- Request accepted on edge T (valid && ready). Strobes are high in cycle T+1; the regfile captures them at the end of T+1.
- `redirect_valid_o` is high in cycle T+2 and uses the updated CSR values. IDLE is re-entered at T+3.
- Back-to-back requests: earliest second accept is at T+3. A held `req_valid_i` is not re-accepted while busy.
- Reset (`rst` low, asynchronous): state←IDLE, latched fields←0, all outputs 0.
- Reset asserted mid-sequence aborts it: no further strobes, no redirect.
- Reset release: `req_ready_o=1` in the first cycle after `rst` goes high.
- `irq_i` dropping after acceptance does not cancel the sequence.

## Configuration
- `TRAP_VECTORED_EN` defined: if `csr_mtvec_i[1:0]==2'b01` and the trap is an interrupt, target = base + 4×code. Exceptions always use base.
- Undefined: mtvec mode bits are ignored; every trap goes to base.

## Test plan
- Exception: cause=2, pc=0x8000_0104, tval=0xDEAD, mtvec=0x8000_1000, mstatus=0x8 -> cycle T+1 mepc=0x8000_0104, mcause=2, mtval=0xDEAD, mstatus=0x1880; cycle T+2 redirect to 0x8000_1000.
- `mret` with mstatus=0x1880, mepc=0x8000_0108 -> RESTORE writes mstatus=0x1888; redirect to 0x8000_0108; mepc/mcause/mtval strobes stay 0.
- Interrupt: irq_i=1, MIE=1, irq_pc=0x8000_0200, mtvec=0x8000_1001 -> mcause=0x8000_0000_0000_0007; redirect to 0x8000_101C with `TRAP_VECTORED_EN`, 0x8000_1000 without.
- Priority: exception, irq and MIE all in the same cycle -> exception taken (mcause=cause); irq with MIE=0 plus `mret` -> `mret` taken.
- Async reset asserted in the SAVE cycle -> outputs go 0 immediately; no redirect; `req_ready_o=1` the cycle after release.
- Back-to-back: `req_valid_i` held high for two exceptions -> accepts at T and T+3; exactly two redirect pulses.
